// File: rtl/lc3b_pkg.sv
// Shared types and constants for the LC-3b memory interface stage.
package lc3b_pkg;

   // Memory-interface FSM encodings
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

   // Response error codes
   typedef enum logic [1:0] {
      ERR_OK        = 2'b00,
      ERR_UNALIGNED = 2'b01,
      ERR_TIMEOUT   = 2'b10
   } mem_err_t;

   // Byte-lane enables: bit0 = [7:0], bit1 = [15:8]
   localparam logic [1:0] MASK_NONE = 2'b00;
   localparam logic [1:0] MASK_LO   = 2'b01;
   localparam logic [1:0] MASK_HI   = 2'b10;
   localparam logic [1:0] MASK_WORD = 2'b11;

   // Sign-extend a byte to a 16-bit word (LDB semantics)
   function automatic logic [15:0] sext8(input logic [7:0] b);
      return {{8{b[7]}}, b};
   endfunction

endpackage

// File: rtl/lc3b_byte_lane.sv
// Byte-lane steering for LC-3b loads and stores: byte select + sign extend
// on the read side, byte replicate + lane mask on the write side. Purely
// combinational so it can also sit on the bus-side LDB path.
module lc3b_byte_lane
   import lc3b_pkg::*;
(
   input  logic        wr_we_i,
   input  logic        wr_byte_i,
   input  logic        wr_addr0_i,
   input  logic [15:0] wr_data_i,
   output logic [15:0] wr_data_o,
   output logic [1:0]  wr_mask_o,
   input  logic        rd_byte_i,
   input  logic        rd_addr0_i,
   input  logic [15:0] rd_data_i,
   output logic [15:0] rd_data_o
);

   // Write side: STB replicates the low byte into both lanes, mask picks one
   always_comb begin
      wr_data_o = wr_data_i;
      wr_mask_o = MASK_NONE;
      if (wr_byte_i) begin
         wr_data_o = {wr_data_i[7:0], wr_data_i[7:0]};
      end
      if (wr_we_i) begin
         if (!wr_byte_i) begin
            wr_mask_o = MASK_WORD;
         end else if (wr_addr0_i) begin
            wr_mask_o = MASK_HI;
         end else begin
            wr_mask_o = MASK_LO;
         end
      end
   end

   // Read side: LDB selects the addressed byte and sign-extends it
   always_comb begin
      rd_data_o = rd_data_i;
      if (rd_byte_i) begin
         rd_data_o = rd_addr0_i ? sext8(rd_data_i[15:8]) : sext8(rd_data_i[7:0]);
      end
   end

endmodule

// File: rtl/lc3b_mem_if.sv
// LC-3b memory interface stage: runs one load/store against a ready-
// handshaked memory and returns an MDR value plus an error code.
//
// Handshake: a request is accepted on any rising edge where
// req_valid & req_ready; req_ready is high only in IDLE, so the requester
// may hold req_valid high and simply wait. rsp_valid is a one-cycle pulse
// (no back-pressure). On the memory side mem_en is held for every ACCESS
// cycle and the access completes on the edge where mem_r is sampled high.
module lc3b_mem_if
   import lc3b_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_byte,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic [1:0]  mem_wmask,
   input  logic [15:0] mem_rdata,
   input  logic        mem_r,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic [1:0]  rsp_err,
   output mem_state_t  dbg_state
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   mem_state_t  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] mar_q, mar_d;
   logic [15:0] mdr_q, mdr_d;
   logic [1:0]  mask_q, mask_d;
   logic        we_q, we_d;
   logic        byte_q, byte_d;
   logic [15:0] rdata_q, rdata_d;
   mem_err_t    err_q, err_d;

   logic [15:0] lane_wdata;
   logic [1:0]  lane_wmask;
   logic [15:0] lane_rdata;
   logic        in_access;

   // Write steering uses the live request (captured on acceptance); read
   // steering uses the registered address/size of the access in flight.
   lc3b_byte_lane u_lane (
      .wr_we_i    (req_we),
      .wr_byte_i  (req_byte),
      .wr_addr0_i (req_addr[0]),
      .wr_data_i  (req_wdata),
      .wr_data_o  (lane_wdata),
      .wr_mask_o  (lane_wmask),
      .rd_byte_i  (byte_q),
      .rd_addr0_i (mar_q[0]),
      .rd_data_i  (mem_rdata),
      .rd_data_o  (lane_rdata)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath-register next values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      mask_d  = mask_q;
      we_d    = we_q;
      byte_d  = byte_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               mar_d   = req_addr;
               mdr_d   = lane_wdata;
               mask_d  = lane_wmask;
               we_d    = req_we;
               byte_d  = req_byte;
               rdata_d = '0;
               cnt_d   = '0;
               if (!req_byte && req_addr[0]) begin
                  // Unaligned word: answer immediately, memory never sees it
                  mask_d  = MASK_NONE;
                  err_d   = ERR_UNALIGNED;
                  state_d = DONE;
               end else begin
                  err_d   = ERR_OK;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            // A ready on the limit cycle still counts as success
            if (mem_r) begin
               err_d   = ERR_OK;
               state_d = DONE;
               if (!we_q) begin
                  rdata_d = lane_rdata;
               end
            end else if (cnt_q == TIMEOUT_C) begin
               err_d   = ERR_TIMEOUT;
               rdata_d = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath registers (MAR, MDR, lane mask, access attributes, response)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         mar_q   <= '0;
         mdr_q   <= '0;
         mask_q  <= MASK_NONE;
         we_q    <= 1'b0;
         byte_q  <= 1'b0;
         rdata_q <= '0;
         err_q   <= ERR_OK;
      end else begin
         cnt_q   <= cnt_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         mask_q  <= mask_d;
         we_q    <= we_d;
         byte_q  <= byte_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Outputs: registers or decodes of state only
   assign in_access = (state_q == ACCESS);
   assign req_ready = (state_q == IDLE);
   assign mem_en    = in_access;
   assign mem_we    = in_access & we_q;
   assign mem_addr  = mar_q;
   assign mem_wdata = mdr_q;
   assign mem_wmask = mask_q;
   assign rsp_valid = (state_q == DONE);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_lc3b_mem_if.sv
// Directed bench for lc3b_mem_if with a response scoreboard.
module tb_lc3b_mem_if;
   import lc3b_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_byte;
   logic [15:0] req_addr, req_wdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  mem_wmask;
   logic        mem_r;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic [1:0]  rsp_err;
   mem_state_t  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   logic [17:0] exp_q[$];

   // Clock
   always #5 clk = ~clk;

   lc3b_mem_if #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_byte  (req_byte),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_rdata (mem_rdata),
      .mem_r     (mem_r),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .dbg_state (dbg_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One transaction: drive request, act as memory, check bus and response.
   // waits = number of ACCESS cycles with mem_r low before mem_r rises; -1 = never.
   task automatic txn(input string name, input logic we, input logic byt,
                      input logic [15:0] addr, input logic [15:0] wd,
                      input logic [15:0] rd, input int waits,
                      input logic [15:0] exp_rd, input logic [1:0] exp_err,
                      input int exp_lat, input logic [15:0] exp_wd,
                      input logic [1:0] exp_mask);
      int n;
      int acc;
      bit got;
      logic exp_access;
      logic [17:0] e;
      exp_access = (exp_err != ERR_UNALIGNED);
      @(negedge clk);
      chk({name, "/req_ready_idle"}, req_ready, 1'b1);
      req_valid = 1'b1;
      req_we    = we;
      req_byte  = byt;
      req_addr  = addr;
      req_wdata = wd;
      exp_q.push_back({exp_err, exp_rd});
      @(negedge clk);
      // Garbage on the request port while busy must be ignored
      req_we    = 1'($urandom_range(0, 1));
      req_byte  = 1'($urandom_range(0, 1));
      req_addr  = 16'($urandom);
      req_wdata = 16'($urandom);
      n   = 1;
      acc = 0;
      got = 1'b0;
      while (!got && n <= 40) begin
         chk({name, "/mem_en"}, mem_en, exp_access && (n < exp_lat));
         chk({name, "/req_ready_busy"}, req_ready, 1'b0);
         if (mem_en) begin
            chk({name, "/mem_we"}, mem_we, we);
            chk({name, "/mem_addr"}, mem_addr, addr);
            chk({name, "/mem_wmask"}, mem_wmask, exp_mask);
            if (we) chk({name, "/mem_wdata"}, mem_wdata, exp_wd);
            mem_r     = (waits >= 0) && (acc == waits);
            mem_rdata = mem_r ? rd : 16'($urandom);
            acc++;
         end else begin
            mem_r     = 1'b0;
            mem_rdata = 16'($urandom);
         end
         if (rsp_valid) begin
            got = 1'b1;
            chk({name, "/latency"}, n, exp_lat);
            chk({name, "/sb_nonempty"}, exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk({name, "/rsp_rdata"}, rsp_rdata, e[15:0]);
               chk({name, "/rsp_err"}, rsp_err, e[17:16]);
            end
         end
         @(negedge clk);
         n++;
      end
      req_valid = 1'b0;
      mem_r     = 1'b0;
      chk({name, "/got_response"}, got, 1'b1);
      chk({name, "/req_ready_after"}, req_ready, 1'b1);
      chk({name, "/rsp_valid_after"}, rsp_valid, 1'b0);
   endtask

   function automatic logic [15:0] ldb_model(input logic a0, input logic [15:0] rd);
      logic [7:0] b;
      b = a0 ? rd[15:8] : rd[7:0];
      return {{8{b[7]}}, b};
   endfunction

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Directed sequence
   initial begin
      logic [15:0] rd;
      logic [15:0] ad;
      int w;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_byte  = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      mem_r     = 1'b0;
      mem_rdata = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst/state", dbg_state, IDLE);
      chk("rst/req_ready", req_ready, 1'b1);
      chk("rst/mem_en", mem_en, 1'b0);
      chk("rst/mem_we", mem_we, 1'b0);
      chk("rst/mem_addr", mem_addr, 16'h0);
      chk("rst/mem_wdata", mem_wdata, 16'h0);
      chk("rst/mem_wmask", mem_wmask, 2'b00);
      chk("rst/rsp_valid", rsp_valid, 1'b0);
      chk("rst/rsp_rdata", rsp_rdata, 16'h0);
      chk("rst/rsp_err", rsp_err, 2'b00);
      rst_n = 1'b1;

      // Word load, zero wait
      txn("ldw", 0, 0, 16'h3000, 16'h0, 16'hBEEF, 0, 16'hBEEF, 2'b00, 2, 16'h0, 2'b00);
      // LDB sign extension
      txn("ldb_hi_neg", 0, 1, 16'h3001, 16'h0, 16'h80FF, 1, 16'hFF80, 2'b00, 3, 16'h0, 2'b00);
      txn("ldb_lo_neg", 0, 1, 16'h3000, 16'h0, 16'h80FF, 1, 16'hFFFF, 2'b00, 3, 16'h0, 2'b00);
      txn("ldb_hi_pos", 0, 1, 16'h3001, 16'h0, 16'h7F12, 0, 16'h007F, 2'b00, 2, 16'h0, 2'b00);
      txn("ldb_lo_pos", 0, 1, 16'h3000, 16'h0, 16'h7F12, 2, 16'h0012, 2'b00, 4, 16'h0, 2'b00);
      // Stores
      txn("stb_hi", 1, 1, 16'h4001, 16'h12AB, 16'h5555, 2, 16'h0000, 2'b00, 4, 16'hABAB, 2'b10);
      txn("stb_lo", 1, 1, 16'h4000, 16'h00CD, 16'h5555, 0, 16'h0000, 2'b00, 2, 16'hCDCD, 2'b01);
      txn("stw", 1, 0, 16'h4002, 16'h1234, 16'hAAAA, 3, 16'h0000, 2'b00, 5, 16'h1234, 2'b11);
      // Unaligned word accesses
      txn("stw_unal", 1, 0, 16'h4003, 16'h5678, 16'h0, 0, 16'h0000, 2'b01, 1, 16'h0, 2'b00);
      txn("ldw_unal", 0, 0, 16'h3005, 16'h0, 16'h0, 0, 16'h0000, 2'b01, 1, 16'h0, 2'b00);
      // Timeout, then ready exactly on the limit cycle
      txn("timeout", 0, 0, 16'h3000, 16'h0, 16'h0, -1, 16'h0000, 2'b10, TO + 2, 16'h0, 2'b00);
      txn("limit_ok", 0, 0, 16'h3004, 16'h0, 16'h1357, TO, 16'h1357, 2'b00, TO + 2, 16'h0, 2'b00);
      txn("st_timeout", 1, 0, 16'h4000, 16'hFFFF, 16'h0, -1, 16'h0000, 2'b10, TO + 2, 16'hFFFF, 2'b11);

      // Reset mid-ACCESS during a slow load
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_byte  = 1'b0;
      req_addr  = 16'h3010;
      @(negedge clk);
      req_valid = 1'b0;
      mem_r     = 1'b0;
      chk("rstmid/in_access", mem_en, 1'b1);
      @(negedge clk);
      chk("rstmid/still_access", mem_en, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rstmid/mem_en", mem_en, 1'b0);
      chk("rstmid/rsp_valid", rsp_valid, 1'b0);
      chk("rstmid/req_ready", req_ready, 1'b1);
      chk("rstmid/mem_addr", mem_addr, 16'h0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("rstmid/no_rsp", rsp_valid, 1'b0);
      end
      txn("after_rst", 0, 0, 16'h3002, 16'h0, 16'hCAFE, 1, 16'hCAFE, 2'b00, 3, 16'h0, 2'b00);

      // Randomised loads with small waits
      for (int i = 0; i < 8; i++) begin
         rd = 16'($urandom);
         w  = $urandom_range(0, 3);
         ad = 16'($urandom);
         if (i % 2 == 0) begin
            ad[0] = 1'b0;
            txn("rnd_ldw", 0, 0, ad, 16'h0, rd, w, rd, 2'b00, 2 + w, 16'h0, 2'b00);
         end else begin
            txn("rnd_ldb", 0, 1, ad, 16'h0, rd, w, ldb_model(ad[0], rd), 2'b00, 2 + w, 16'h0, 2'b00);
         end
      end

      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lc3b_mem_if.md
# lc3b_mem_if

Memory interface stage for the LC-3b datapath. It consumes the 16-bit address selected by the MARMUX-style 4:1 select stage and the store data from the register file. It runs one read or write transaction against a ready-handshaked memory, then returns a 16-bit MDR value to the bus. It handles LDB/STB byte lanes, LDW/STW word accesses, unaligned-word detection and a memory-ready timeout.

## Interface
Parameters:
- TIMEOUT, 255: maximum ACCESS-state cycles without mem_r before an error response; valid range 1–255.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  control FSM requests an access.
- req_ready  out  1  block is idle and accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access (LDB/STB), 0 = word.
- req_addr  in  16  address from the address select stage.
- req_wdata  in  16  store data; STB uses bits [7:0].
- mem_en  out  1  memory request strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  registered address (MAR).
- mem_wdata  out  16  registered write data.
- mem_wmask  out  2  byte-lane enables; bit0 = [7:0], bit1 = [15:8].
- mem_rdata  in  16  read data; valid when mem_r = 1.
- mem_r  in  1  memory ready; completes the access.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  16  MDR value; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 unaligned word, 10 timeout.

## Operation
- States: IDLE, ACCESS, DONE.
- Handshake: req_ready = 1 only in IDLE. A request is accepted on a cycle with req_valid & req_ready. On acceptance the block registers MAR, MDR, we, byte and the lane mask.
- Unaligned check: a word access with req_addr[0] = 1 goes IDLE → DONE with rsp_err = 01. It never asserts mem_en.
- Otherwise the block goes IDLE → ACCESS. mem_en = 1 for every ACCESS cycle. mem_we = registered we. mem_addr = MAR.
- Write lanes:
  - Word: wmask = 11.
  - Byte: wdata = {b,b} where b = req_wdata[7:0]. wmask = 01 when addr[0] = 0, 10 when addr[0] = 1.
  - Loads: wmask = 00.
- Read data, captured in the ACCESS cycle where mem_r = 1:
  - Word: rdata unchanged.
  - Byte: select byte [7:0] when addr[0] = 0, [15:8] when addr[0] = 1, then sign-extend to 16 bits.
- ACCESS → DONE when mem_r = 1, with rsp_err = 00.
- Timeout: a cycle counter clears on entry to ACCESS. When the count reaches TIMEOUT with mem_r still 0, the block goes ACCESS → DONE with rsp_err = 10 and rsp_rdata = 0. If mem_r = 1 in the same cycle as the limit, the success path wins.
- DONE lasts exactly one cycle with rsp_valid = 1, then → IDLE. A new request is accepted no earlier than the cycle after DONE.
- req_* inputs are ignored outside IDLE.
- mem_rdata is ignored outside ACCESS and when mem_r = 0.

## Timing
- Reset (rst_n = 0 sampled at a rising edge):
  - State → IDLE; counter = 0.
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_wmask = 00.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 00; req_ready = 1 after reset.
- Reset mid-ACCESS: mem_en is low from the next edge and no response is issued.
- All outputs are registered or decoded from state only. No combinational path runs from req_* or mem_* to any output.
- Minimum access latency: accept at cycle T; ACCESS at T+1 with mem_r = 1; rsp_valid at T+2.
- Latency with n wait cycles: rsp_valid at T+2+n.
- Unaligned error: rsp_valid at T+1.
- Timeout: rsp_valid at T+1+TIMEOUT+1 when mem_r never rises.
- Back-to-back: request accept cycles can be no closer than 3 cycles apart.

## Structure
- lc3b_pkg holds:
  - state encodings: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  - error codes: ERR_OK, ERR_UNALIGNED, ERR_TIMEOUT;
  - the lane-mask constants.
- Single sub-module lc3b_byte_lane: combinational byte select plus sign extend for reads, and byte replicate plus mask generation for writes. It is shared with the future LDB path in the bus logic.
- The FSM, registers and timeout counter live in lc3b_mem_if.

## Test plan
- Word load: addr = 0x3000, mem_r high on the first ACCESS cycle, rdata = 0xBEEF → rsp_valid at T+2 with rsp_rdata = 0xBEEF and err = 00.
- LDB sign extension: addr = 0x3001, rdata = 0x80FF → rsp_rdata = 0xFF80. At addr = 0x3000 → rsp_rdata = 0xFFFF. With rdata = 0x7F12 at 0x3001 → 0x007F.
- STB: addr = 0x4001, wdata = 0x12AB → mem_wdata = 0xABAB, mem_wmask = 10, mem_we = 1 throughout ACCESS, rsp_rdata = 0.
- Unaligned STW to 0x4003 → mem_en never asserts; rsp_valid at T+1 with err = 01; req_ready again at T+2.
- Timeout with TIMEOUT = 4 and mem_r held 0 → rsp_err = 10 at T+6. Repeat with mem_r rising exactly on the limit cycle → err = 00.
- Reset mid-ACCESS, with rst_n low for one cycle during a 10-wait load → mem_en = 0 and rsp_valid = 0 next cycle. A following request then completes normally.
